// File: rtl/psram_frame_sched.sv
// psram_frame_sched: picks write (camera FIFO -> PSRAM) or read (PSRAM -> display
// FIFO) bursts and drives the burst controller Go/Addr/Wr handshake.
// Ports: clk160_i/rst_n clock and async low reset; cfgDone controller ready;
//   wr_fifo_count/rd_fifo_free FIFO levels; frame_start/disp_frame_start frame
//   pulses; brst_Go/brst_Addr_in/brst_Wr request; brst_Done controller idle;
//   wr_frame_done/frame_valid/busy status.
module psram_frame_sched #(
  parameter int BURST_LEN   = 32,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_AW     = 10
) (
  input  logic             clk160_i,
  input  logic             rst_n,
  input  logic             cfgDone,
  input  logic [FIFO_AW:0] wr_fifo_count,
  input  logic [FIFO_AW:0] rd_fifo_free,
  input  logic             frame_start,
  input  logic             disp_frame_start,
  output logic             brst_Go,
  output logic [22:0]      brst_Addr_in,
  output logic             brst_Wr,
  input  logic             brst_Done,
  output logic             wr_frame_done,
  output logic             frame_valid,
  output logic             busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARB  = 3'd1;
  localparam logic [2:0] REQ  = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] UPD  = 3'd4;

  localparam logic [FIFO_AW:0] BL_C  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [FIFO_AW:0] BL2_C = (FIFO_AW+1)'(2*BURST_LEN);
  localparam logic [22:0] BL_A   = 23'(BURST_LEN);
  localparam logic [22:0] FW_A   = 23'(FRAME_WORDS);
  localparam logic [22:0] LAST_A = 23'(FRAME_WORDS - BURST_LEN);

  logic [2:0]  state_q, state_d;
  logic [22:0] wr_ptr_q, rd_ptr_q, addr_q;
  logic        wr_buf_q, ready_buf_q, rd_buf_q;
  logic        last_wr_q, fs_pend_q, dfs_pend_q;
  logic        go_q, wr_q, fd_q, fv_q, busy_q;

  logic        wr_elig, rd_elig, wr_urgent, any_elig, pick_wr;
  logic        in_flight, wr_inflight, rd_inflight, upd;
  logic [22:0] wr_addr, rd_addr, rd_ptr_nxt;

  assign brst_Go       = go_q;
  assign brst_Addr_in  = addr_q;
  assign brst_Wr       = wr_q;
  assign wr_frame_done = fd_q;
  assign frame_valid   = fv_q;
  assign busy          = busy_q;

  assign wr_elig   = wr_fifo_count >= BL_C;
  assign wr_urgent = wr_fifo_count >= BL2_C;
  assign rd_elig   = (rd_fifo_free >= BL_C) && fv_q;
  assign any_elig  = wr_elig || rd_elig;
  // urgent write first, else round-robin when both want the bus
  assign pick_wr   = wr_urgent ||
                     (wr_elig && (!rd_elig || !last_wr_q));

  assign wr_addr    = (wr_buf_q ? FW_A : 23'd0) + wr_ptr_q;
  assign rd_addr    = (rd_buf_q ? FW_A : 23'd0) + rd_ptr_q;
  assign rd_ptr_nxt = (rd_ptr_q == LAST_A) ? 23'd0 : rd_ptr_q + BL_A;

  assign upd         = state_q == UPD;
  assign in_flight   = (state_q == REQ) || (state_q == RUN) || upd;
  assign wr_inflight = in_flight && wr_q;
  assign rd_inflight = in_flight && !wr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfgDone && brst_Done) state_d = ARB;
      ARB:  if (any_elig) state_d = REQ;
      REQ:  if (!brst_Done) state_d = RUN;
      RUN:  if (brst_Done) state_d = UPD;
      UPD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk160_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= '0;
      wr_buf_q    <= 1'b0;
      ready_buf_q <= 1'b0;
      rd_buf_q    <= 1'b0;
      last_wr_q   <= 1'b0;
      fs_pend_q   <= 1'b0;
      dfs_pend_q  <= 1'b0;
      go_q        <= 1'b0;
      wr_q        <= 1'b0;
      fd_q        <= 1'b0;
      fv_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      fd_q    <= 1'b0;

      if (state_q == ARB && any_elig) begin
        go_q   <= 1'b1;
        busy_q <= 1'b1;
        wr_q   <= pick_wr;
        addr_q <= pick_wr ? wr_addr : rd_addr;
      end
      if (state_q == REQ && !brst_Done) go_q <= 1'b0;
      if (upd) begin
        busy_q    <= 1'b0;
        last_wr_q <= wr_q;
      end

      // a frame_start landing in the write's UPD cycle is applied there
      if (upd && wr_q) begin
        if (fs_pend_q || frame_start) begin
          wr_ptr_q  <= '0;
          fs_pend_q <= 1'b0;
        end else if (wr_ptr_q == LAST_A) begin
          wr_ptr_q    <= '0;
          ready_buf_q <= wr_buf_q;
          wr_buf_q    <= !wr_buf_q;
          fv_q        <= 1'b1;
          fd_q        <= 1'b1;
        end else begin
          wr_ptr_q <= wr_ptr_q + BL_A;
        end
      end else if (frame_start) begin
        if (wr_inflight) fs_pend_q <= 1'b1;
        else wr_ptr_q <= '0;
      end

      if (upd && !wr_q) begin
        if (dfs_pend_q || disp_frame_start) begin
          rd_ptr_q   <= '0;
          rd_buf_q   <= ready_buf_q;
          dfs_pend_q <= 1'b0;
        end else begin
          rd_ptr_q <= rd_ptr_nxt;
        end
      end else if (disp_frame_start) begin
        if (rd_inflight) begin
          dfs_pend_q <= 1'b1;
        end else begin
          rd_ptr_q <= '0;
          rd_buf_q <= ready_buf_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_frame_sched.sv
// tb_psram_frame_sched: directed bench for psram_frame_sched with a small
// burst-controller stub; FRAME_WORDS shrunk to 128 so frames wrap quickly.
module tb_psram_frame_sched;

  localparam int BL  = 32;
  localparam int FW  = 128;
  localparam int FAW = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfgDone;
  logic [FAW:0]   wr_cnt;
  logic [FAW:0]   rd_free;
  logic           fs;
  logic           dfs;
  logic           brst_Go;
  logic [22:0]    brst_Addr_in;
  logic           brst_Wr;
  logic           brst_Done;
  logic           wr_frame_done;
  logic           frame_valid;
  logic           busy;

  int total = 0;
  int bad   = 0;

  int acc_dly = 0;
  int run_len = 4;
  int st, acnt, rcnt, nb, fd_cnt;
  logic [22:0] addr_log [0:63];
  logic        wr_log   [0:63];
  int          fd_nb    [0:7];

  always #3 clk = ~clk;

  psram_frame_sched #(
    .BURST_LEN(BL),
    .FRAME_WORDS(FW),
    .FIFO_AW(FAW)
  ) dut (
    .clk160_i(clk),
    .rst_n(rst_n),
    .cfgDone(cfgDone),
    .wr_fifo_count(wr_cnt),
    .rd_fifo_free(rd_free),
    .frame_start(fs),
    .disp_frame_start(dfs),
    .brst_Go(brst_Go),
    .brst_Addr_in(brst_Addr_in),
    .brst_Wr(brst_Wr),
    .brst_Done(brst_Done),
    .wr_frame_done(wr_frame_done),
    .frame_valid(frame_valid),
    .busy(busy)
  );

  // controller stub: accepts Go after acc_dly extra cycles, busy for run_len
  initial begin
    brst_Done = 1'b1;
    st = 0; acnt = 0; rcnt = 0; nb = 0; fd_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        brst_Done = 1'b1;
        st = 0; acnt = 0; rcnt = 0; nb = 0; fd_cnt = 0;
      end else begin
        if (wr_frame_done && fd_cnt < 8) begin
          fd_nb[fd_cnt] = nb;
          fd_cnt++;
        end
        if (st == 0) begin
          if (brst_Go) begin
            if (acnt >= acc_dly) begin
              brst_Done = 1'b0;
              st = 1;
              rcnt = 0;
              if (nb < 64) begin
                addr_log[nb] = brst_Addr_in;
                wr_log[nb]   = brst_Wr;
              end
              nb++;
            end else begin
              acnt++;
            end
          end else begin
            acnt = 0;
          end
        end else begin
          rcnt++;
          if (rcnt >= run_len) begin
            brst_Done = 1'b1;
            st = 0;
            acnt = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cfgDone = 1'b1;
    wr_cnt = '0; rd_free = '0;
    fs = 1'b0; dfs = 1'b0;
    acc_dly = 0; run_len = 4;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_nb(input int target);
    int i;
    i = 0;
    while (nb < target && i < 3000) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (nb < target) begin
      bad++;
      $display("FAIL wait_nb: bursts=%0d need=%0d", nb, target);
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy === 1'b1 || brst_Go === 1'b1) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b", busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfgDone = 1'b0;
    wr_cnt = 11'd64; rd_free = '0;
    fs = 1'b0; dfs = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (brst_Go !== 1'b0) begin
      bad++; $display("FAIL rst_go: got=%b exp=0", brst_Go);
    end
    total++;
    if (brst_Addr_in !== 23'd0) begin
      bad++; $display("FAIL rst_addr: got=%0d exp=0", brst_Addr_in);
    end
    total++;
    if (brst_Wr !== 1'b0) begin
      bad++; $display("FAIL rst_wr: got=%b exp=0", brst_Wr);
    end
    total++;
    if (wr_frame_done !== 1'b0) begin
      bad++; $display("FAIL rst_fd: got=%b exp=0", wr_frame_done);
    end
    total++;
    if (frame_valid !== 1'b0) begin
      bad++; $display("FAIL rst_fv: got=%b exp=0", frame_valid);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy: got=%b exp=0", busy);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (brst_Go !== 1'b0) begin
      bad++; $display("FAIL nocfg_go: got=%b exp=0", brst_Go);
    end
    cfgDone = 1'b1;
    @(negedge clk);
    total++;
    if (brst_Go !== 1'b0) begin
      bad++; $display("FAIL lat1_go: got=%b exp=0", brst_Go);
    end
    @(negedge clk);
    total++;
    if (brst_Go !== 1'b1) begin
      bad++; $display("FAIL lat2_go: got=%b exp=1", brst_Go);
    end
    total++;
    if (brst_Wr !== 1'b1) begin
      bad++; $display("FAIL lat2_wr: got=%b exp=1", brst_Wr);
    end
    total++;
    if (brst_Addr_in !== 23'd0) begin
      bad++; $display("FAIL lat2_addr: got=%0d exp=0", brst_Addr_in);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL lat2_busy: got=%b exp=1", busy);
    end
  endtask

  task automatic test_write_stream();
    do_reset();
    total++;
    if (frame_valid !== 1'b0) begin
      bad++; $display("FAIL ws_fv0: got=%b exp=0", frame_valid);
    end
    wr_cnt = 11'd64;
    wait_nb(8);
    wr_cnt = '0;
    wait_idle();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (addr_log[k] !== 23'(k * BL) || wr_log[k] !== 1'b1) begin
        bad++;
        $display("FAIL ws_addr%0d: got=%0d/%b exp=%0d/1",
                 k, addr_log[k], wr_log[k], k * BL);
      end
    end
    total++;
    if (fd_cnt !== 2 || fd_nb[0] !== 4 || fd_nb[1] !== 8) begin
      bad++;
      $display("FAIL ws_fdone: got=%0d pulses at %0d,%0d exp=2 at 4,8",
               fd_cnt, fd_nb[0], fd_nb[1]);
    end
    total++;
    if (frame_valid !== 1'b1) begin
      bad++; $display("FAIL ws_fv1: got=%b exp=1", frame_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [22:0] exp_a [0:6];
    logic        exp_w [0:6];
    exp_a[0] = 23'd0;   exp_w[0] = 1'b0;
    exp_a[1] = 23'd128; exp_w[1] = 1'b1;
    exp_a[2] = 23'd32;  exp_w[2] = 1'b0;
    exp_a[3] = 23'd160; exp_w[3] = 1'b1;
    exp_a[4] = 23'd192; exp_w[4] = 1'b1;
    exp_a[5] = 23'd224; exp_w[5] = 1'b1;
    exp_a[6] = 23'd0;   exp_w[6] = 1'b1;
    do_reset();
    wr_cnt = 11'd64;
    wait_nb(4);
    wr_cnt = '0;
    wait_idle();
    wr_cnt = 11'd40;
    rd_free = 11'd64;
    wait_nb(8);
    wr_cnt = 11'd64;
    wait_nb(11);
    wr_cnt = '0;
    rd_free = '0;
    wait_idle();
    for (int k = 0; k < 7; k++) begin
      total++;
      if (addr_log[k+4] !== exp_a[k] || wr_log[k+4] !== exp_w[k]) begin
        bad++;
        $display("FAIL rr_b%0d: got=%0d/%b exp=%0d/%b",
                 k, addr_log[k+4], wr_log[k+4], exp_a[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    run_len = 8;
    wr_cnt = 11'd64;
    wait_nb(3);
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    wait_nb(5);
    wr_cnt = '0;
    wait_idle();
    total++;
    if (addr_log[2] !== 23'd64) begin
      bad++; $display("FAIL fs_pre: got=%0d exp=64", addr_log[2]);
    end
    total++;
    if (addr_log[3] !== 23'd0 || wr_log[3] !== 1'b1) begin
      bad++;
      $display("FAIL fs_restart: got=%0d/%b exp=0/1", addr_log[3], wr_log[3]);
    end
    total++;
    if (addr_log[4] !== 23'd32) begin
      bad++; $display("FAIL fs_next: got=%0d exp=32", addr_log[4]);
    end
    total++;
    if (frame_valid !== 1'b0 || fd_cnt !== 0) begin
      bad++;
      $display("FAIL fs_nofv: got fv=%b pulses=%0d exp fv=0 pulses=0",
               frame_valid, fd_cnt);
    end
  endtask

  task automatic test_disp_frame();
    do_reset();
    wr_cnt = 11'd64;
    wait_nb(8);
    wr_cnt = '0;
    wait_idle();
    dfs = 1'b1;
    @(negedge clk);
    dfs = 1'b0;
    rd_free = 11'd64;
    wait_nb(10);
    rd_free = '0;
    wait_idle();
    total++;
    if (addr_log[8] !== 23'd128 || wr_log[8] !== 1'b0) begin
      bad++;
      $display("FAIL dfs_rd0: got=%0d/%b exp=128/0", addr_log[8], wr_log[8]);
    end
    total++;
    if (addr_log[9] !== 23'd160 || wr_log[9] !== 1'b0) begin
      bad++;
      $display("FAIL dfs_rd1: got=%0d/%b exp=160/0", addr_log[9], wr_log[9]);
    end
  endtask

  task automatic test_hold_go();
    int i;
    int hi;
    logic done_at_fall;
    do_reset();
    acc_dly = 9;
    wr_cnt = 11'd64;
    i = 0;
    while (!brst_Go && i < 100) begin
      @(negedge clk);
      i++;
    end
    wr_cnt = '0;
    hi = 0;
    while (brst_Go && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    done_at_fall = brst_Done;
    total++;
    if (hi !== 10) begin
      bad++; $display("FAIL hold_cycles: got=%0d exp=10", hi);
    end
    total++;
    if (done_at_fall !== 1'b0) begin
      bad++; $display("FAIL hold_fall: brst_Done got=%b exp=0", done_at_fall);
    end
    wait_idle();
    repeat (10) @(negedge clk);
    total++;
    if (nb !== 1) begin
      bad++; $display("FAIL hold_once: bursts got=%0d exp=1", nb);
    end
    acc_dly = 0;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    wr_cnt = 11'd64;
    wait_nb(2);
    @(negedge clk);
    total++;
    if (brst_Addr_in !== 23'd32 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mr_pre: got addr=%0d busy=%b exp 32/1",
               brst_Addr_in, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({brst_Go, brst_Addr_in, brst_Wr, wr_frame_done,
         frame_valid, busy} !== 28'd0) begin
      bad++;
      $display("FAIL mr_zero: got go=%b addr=%0d wr=%b fd=%b fv=%b busy=%b",
               brst_Go, brst_Addr_in, brst_Wr, wr_frame_done,
               frame_valid, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_nb(1);
    wr_cnt = '0;
    wait_idle();
    total++;
    if (addr_log[0] !== 23'd0 || wr_log[0] !== 1'b1) begin
      bad++;
      $display("FAIL mr_first: got=%0d/%b exp=0/1", addr_log[0], wr_log[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfgDone = 1'b0;
    wr_cnt = '0;
    rd_free = '0;
    fs = 1'b0;
    dfs = 1'b0;
    test_reset();
    test_write_stream();
    test_round_robin();
    test_frame_start();
    test_disp_frame();
    test_hold_go();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
